// File: rtl/gl_pkg.sv
// Shared types and constants for the triangle assembly / dispatch path.
// Vertex layout is {x, y, z}, each an IEEE-754 single.
package gl_pkg;

    localparam int unsigned VTX_W = 96;
    localparam int unsigned TRI_W = 288;

    localparam int unsigned X_MSB = 95;
    localparam int unsigned Y_MSB = 63;
    localparam int unsigned Z_MSB = 31;

    typedef enum logic [1:0] {
        DSP_IDLE,
        DSP_ISSUE,
        DSP_WAIT
    } dsp_state_e;

endpackage

// File: rtl/gl_tri_dispatch_if.sv
// Vertex input stream and rasterizer dispatch handshake.
// slave is the dispatcher's view, master the environment's view.
interface gl_tri_dispatch_if;
    import gl_pkg::*;

    logic             vtx_valid;
    logic [VTX_W-1:0] vtx_data;
    logic             vtx_last;
    logic             vtx_ready;
    logic             tri_start;
    logic [VTX_W-1:0] tri_v1;
    logic [VTX_W-1:0] tri_v2;
    logic [VTX_W-1:0] tri_v3;
    logic             raster_done;

    modport slave (
        input  vtx_valid, vtx_data, vtx_last, raster_done,
        output vtx_ready, tri_start, tri_v1, tri_v2, tri_v3
    );

    modport master (
        output vtx_valid, vtx_data, vtx_last, raster_done,
        input  vtx_ready, tri_start, tri_v1, tri_v2, tri_v3
    );

endinterface

// File: rtl/gl_tri_fifo.sv
// Synchronous TRI_W x DEPTH triangle FIFO; head reads as zero while empty.
module gl_tri_fifo
    import gl_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned LW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [TRI_W-1:0] push_data,
    input  logic             pop,
    output logic [TRI_W-1:0] head,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [TRI_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
        else if (!push_ok && pop_ok) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    // Masking keeps the outputs at zero after reset without resetting storage.
    assign head  = empty ? '0 : mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/gl_tri_dispatch.sv
// Triangle assembly and rasterizer dispatch. Strip assembly with alternating
// winding is compiled in with GL_TRI_STRIP_EN; otherwise list assembly only.
module gl_tri_dispatch
    import gl_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned LW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    gl_tri_dispatch_if.slave bus,
    input  logic             strip_mode,
    output logic             busy,
    output logic [LW-1:0]    fifo_level,
    output logic [CNT_W-1:0] tri_issued,
    output logic [CNT_W-1:0] vtx_dropped
);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    logic [1:0]       vcnt_q, vcnt_d;
    logic [VTX_W-1:0] va_q, va_d, vb_q, vb_d;
    logic [CNT_W-1:0] issued_q, issued_d, dropped_q, dropped_d;
    logic [1:0]       drop_n;
    logic             accept, push, pop, full, empty;
    logic [TRI_W-1:0] push_tri, head;
    dsp_state_e       state_q, state_d;
    logic             tri_start_q, tri_start_d;

`ifdef GL_TRI_STRIP_EN
    logic parity_q, parity_d, mode_q, mode_d, strip_now;
    // Mode is latched at the first vertex so a strip cannot change type midway.
    assign strip_now = (vcnt_q == 2'd0) ? strip_mode : mode_q;
`else
    logic unused_strip_mode;
    assign unused_strip_mode = strip_mode;
`endif

    assign accept = bus.vtx_valid && bus.vtx_ready;

    always_comb begin
        vcnt_d   = vcnt_q;
        va_d     = va_q;
        vb_d     = vb_q;
        push     = 1'b0;
        push_tri = {va_q, vb_q, bus.vtx_data};
        drop_n   = 2'd0;
`ifdef GL_TRI_STRIP_EN
        parity_d = parity_q;
        mode_d   = mode_q;
`endif
        if (accept) begin
`ifdef GL_TRI_STRIP_EN
            if (vcnt_q == 2'd0) mode_d = strip_mode;
            if (strip_now && vcnt_q == 2'd2) begin
                push     = 1'b1;
                push_tri = parity_q ? {vb_q, va_q, bus.vtx_data} : {va_q, vb_q, bus.vtx_data};
                va_d     = vb_q;
                vb_d     = bus.vtx_data;
                parity_d = !parity_q;
                if (bus.vtx_last) begin
                    vcnt_d   = 2'd0;
                    parity_d = 1'b0;
                end
            end else
`endif
            if (vcnt_q == 2'd2) begin
                push   = 1'b1;
                vcnt_d = 2'd0;
            end else if (bus.vtx_last) begin
                drop_n = vcnt_q + 2'd1;
                vcnt_d = 2'd0;
`ifdef GL_TRI_STRIP_EN
                parity_d = 1'b0;
`endif
            end else begin
                if (vcnt_q == 2'd0) va_d = bus.vtx_data;
                else                vb_d = bus.vtx_data;
                vcnt_d = vcnt_q + 2'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        tri_start_d = 1'b0;
        pop         = 1'b0;
        unique case (state_q)
            DSP_IDLE: begin
                if (!empty) begin
                    state_d     = DSP_ISSUE;
                    tri_start_d = 1'b1;
                end
            end
            DSP_ISSUE: state_d = DSP_WAIT;
            DSP_WAIT: begin
                if (bus.raster_done) begin
                    pop     = 1'b1;
                    state_d = DSP_IDLE;
                end
            end
            default: state_d = DSP_IDLE;
        endcase
        issued_d  = pop ? sat_add(issued_q, CNT_W'(1)) : issued_q;
        dropped_d = sat_add(dropped_q, CNT_W'(drop_n));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DSP_IDLE;
            tri_start_q <= 1'b0;
            vcnt_q      <= 2'd0;
            va_q        <= '0;
            vb_q        <= '0;
            issued_q    <= '0;
            dropped_q   <= '0;
`ifdef GL_TRI_STRIP_EN
            parity_q    <= 1'b0;
            mode_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tri_start_q <= tri_start_d;
            vcnt_q      <= vcnt_d;
            va_q        <= va_d;
            vb_q        <= vb_d;
            issued_q    <= issued_d;
            dropped_q   <= dropped_d;
`ifdef GL_TRI_STRIP_EN
            parity_q    <= parity_d;
            mode_q      <= mode_d;
`endif
        end
    end

    gl_tri_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(push_tri),
        .pop      (pop),
        .head     (head),
        .level    (fifo_level),
        .full     (full),
        .empty    (empty)
    );

    assign bus.vtx_ready = !full;
    assign bus.tri_start = tri_start_q;
    assign {bus.tri_v1, bus.tri_v2, bus.tri_v3} = head;
    assign busy          = (state_q != DSP_IDLE) || (fifo_level != '0);
    assign tri_issued    = issued_q;
    assign vtx_dropped   = dropped_q;

endmodule
